// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), result is value mod 10^DIGITS.
// Optional leading-zero blanking (4'hF digits) enabled by defining LEAD_ZERO_BLANK_EN.
module bin2bcd_seq #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(IN_WIDTH) + 1;
    localparam int BW = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [BW-1:0]       bcd_q, bcd_d;

    logic [BW-1:0]       adjusted;
    logic [BW-1:0]       shifted;
    logic [BW-1:0]       result;
    logic                carryOut;

`ifdef LEAD_ZERO_BLANK_EN
    // Digit 0 always stays visible so a zero result still shows one digit.
    function automatic logic [BW-1:0] blankLeading(input logic [BW-1:0] d);
        logic lead;
        blankLeading = d;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (d[4*k +: 4] == 4'd0)) begin
                blankLeading[4*k +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    endfunction
`endif

    always_comb begin
        adjusted = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // The bit leaving the top digit is dropped, which keeps the result modulo 10^DIGITS.
    assign shifted  = {adjusted[BW-2:0], shreg_q[IN_WIDTH-1]};
    assign carryOut = adjusted[BW-1];

`ifdef LEAD_ZERO_BLANK_EN
    assign result = blankLeading(shifted);
`else
    assign result = shifted;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = value;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = {shreg_q[IN_WIDTH-2:0], 1'b0};
                scratch_d = shifted;
                sticky_d  = sticky_q | carryOut;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(IN_WIDTH - 1)) begin
                    bcd_d   = result;
                    ovf_d   = sticky_q | carryOut;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed + randomized bench for bin2bcd_seq, checked against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    localparam int IN_WIDTH = 32;
    localparam int DIGITS   = 4;
    localparam int BW       = 4 * DIGITS;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [IN_WIDTH-1:0] value;
    logic                busy;
    logic                done;
    logic [BW-1:0]       bcd;
    logic                overflow;

    int passCount  = 0;
    int totalCount = 0;

    bin2bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of v mod 10^DIGITS, optionally blanking leading zeros.
    function automatic logic [BW-1:0] modelBcd(input logic [IN_WIDTH-1:0] v);
        longint unsigned r;
        int digit[DIGITS];
        int msd;
        logic [BW-1:0] out;
        r   = longint'(v) % 64'd10000;
        msd = 0;
        out = '0;
        for (int k = 0; k < DIGITS; k++) begin
            digit[k] = int'(r % 10);
            r = r / 10;
            if (digit[k] != 0) msd = k;
        end
        for (int k = 0; k < DIGITS; k++) begin
            out[4*k +: 4] = 4'(digit[k]);
`ifdef LEAD_ZERO_BLANK_EN
            if (k > msd) out[4*k +: 4] = 4'hF;
`endif
        end
        return out;
    endfunction

    function automatic logic modelOvf(input logic [IN_WIDTH-1:0] v);
        return (longint'(v) >= 64'd10000);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Called at a negedge; start is sampled by the next rising edge.
    task automatic applyStimulus(input logic [IN_WIDTH-1:0] v);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
    endtask

    // Returns at the negedge of the done cycle, so a start can be issued right there.
    task automatic waitDone(input string tag, input logic [IN_WIDTH-1:0] v,
                            input int pokeAt, input logic [IN_WIDTH-1:0] pokeVal);
        int busyCnt = 0;
        int doneIdx = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busyCnt++;
            if (done) begin
                doneIdx = i;
                break;
            end
            if (i == pokeAt) begin
                start = 1'b1;
                value = pokeVal;
            end else begin
                start = 1'b0;
                value = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, "_doneIdx"}, 64'(doneIdx), 64'd32);
        checkOutput({tag, "_busyCnt"}, 64'(busyCnt), 64'd32);
        checkOutput({tag, "_bcd"}, 64'(bcd), 64'(modelBcd(v)));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(modelOvf(v)));
    endtask

    task automatic holdCheck(input string tag, input logic [IN_WIDTH-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput({tag, "_holdDone"}, 64'(done), 64'd0);
            checkOutput({tag, "_holdBcd"}, 64'(bcd), 64'(modelBcd(v)));
            checkOutput({tag, "_holdOvf"}, 64'(overflow), 64'(modelOvf(v)));
        end
    endtask

    task automatic convert(input string tag, input logic [IN_WIDTH-1:0] v);
        applyStimulus(v);
        waitDone(tag, v, -1, '0);
    endtask

    logic [IN_WIDTH-1:0] directed[6] = '{32'd0, 32'd7, 32'd9999, 32'd10000, 32'd10305, 32'd99};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_bcd", 64'(bcd), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_done", 64'(done), 64'h0);
        checkOutput("rst_ovf", 64'(overflow), 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_bcd", 64'(bcd), 64'h0);
            checkOutput("idle_busy", 64'(busy), 64'h0);
            checkOutput("idle_done", 64'(done), 64'h0);
        end

        convert("v1234", 32'd1234);
        holdCheck("v1234", 32'd1234, 3);

        convert("vmax", 32'hFFFF_FFFF);
        convert("v9999", 32'd9999);

        applyStimulus(32'd500);
        waitDone("v500", 32'd500, 9, 32'd42);
        applyStimulus(32'd42);
        waitDone("v42", 32'd42, -1, '0);
        holdCheck("v42", 32'd42, 1);

        applyStimulus(32'd8765);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'h0);
        checkOutput("abort_bcd", 64'(bcd), 64'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("abort_done", 64'(done), 64'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_idleDone", 64'(done), 64'h0);
        convert("v8765", 32'd8765);

        for (int i = 0; i < 6; i++) begin
            convert($sformatf("dir%0d", i), directed[i]);
        end

        for (int i = 0; i < 8; i++) begin
            logic [IN_WIDTH-1:0] rv;
            rv = ($urandom_range(0, 3) == 0) ? IN_WIDTH'($urandom) : IN_WIDTH'($urandom_range(0, 20000));
            convert($sformatf("rnd%0d", i), rv);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
